idli_uart_rx_m: RTL and testbench
=================================

Name: idli_uart_rx_m

Overview:
Serial UART receiver for the idli core, the receive counterpart of the existing UART transmitter. It samples the raw RX line, deframes 8N1 characters LSB-first and holds each received byte in a one-byte buffer. It presents that byte to the core as two sqi_data_t nibbles, low nibble first, over a vld/acp handshake that matches the nibble-serial datapath. It also flags framing errors and overruns.

Parameters:
CLKS_PER_BIT, 16, gck cycles per bit; even, >= 4.
SYNC_STAGES, 2, flops in the RX input synchroniser; >= 2.

Ports:
i_uart_rx_gck  input  1  clock; the same undivided gck used by the transmitter.
i_uart_rx_rst  input  1  reset; synchronous, active-high.
i_uart_rx  input  1  raw asynchronous serial line; idles high.
o_uart_rx_data  output  4  nibble to core, sqi_data_t.
o_uart_rx_vld  output  1  o_uart_rx_data valid.
i_uart_rx_acp  input  1  core accepts the nibble this cycle.
o_uart_rx_hi  output  1  0 = low nibble presented, 1 = high nibble presented.
o_uart_rx_frame_err  output  1  one-cycle pulse: stop bit sampled low.
o_uart_rx_overrun  output  1  one-cycle pulse: byte completed while the buffer was still full.
o_uart_rx_parity_err  output  1  one-cycle pulse on parity mismatch; tied 0 when the optional feature is out.

Behaviour:
- Reset:
  - All outputs 0.
  - FSM in IDLE; baud counter and bit counter 0; buffer empty.
  - Synchroniser flops reset to 1 (idle line).
  - Reset mid-frame abandons the frame; no pulses are generated.
- Synchronised line rxs is the output of the SYNC_STAGES flop chain. All decisions use rxs.
- Baud counter cnt runs 0..CLKS_PER_BIT-1 and reloads 0 on every state entry.
- FSM (uart_rx_state_t): IDLE, START, DATA, [PARITY], STOP, WAIT_IDLE.
  - IDLE: rxs==0 -> START.
  - START: at cnt==CLKS_PER_BIT/2-1, sample rxs.
    - 1: false start -> IDLE.
    - 0: -> DATA; cnt=0 (sampling now mid-bit).
  - DATA: at cnt==CLKS_PER_BIT-1, shift rxs into shreg[7] (right shift, so the byte arrives LSB-first); bit count increments.
    - After the 8th bit -> STOP, or PARITY when the feature is compiled in.
  - STOP: at cnt==CLKS_PER_BIT-1, sample rxs.
    - 1: commit the byte -> IDLE. A new start can be detected from the next cycle, i.e. at mid-stop-bit.
    - 0: pulse frame_err, discard the byte -> WAIT_IDLE.
  - WAIT_IDLE: rxs==1 -> IDLE. This prevents a held-low break from producing repeated errors.
- Commit (the cycle after the stop sample):
  - Buffer empty: load it; o_uart_rx_vld=1, o_uart_rx_hi=0, o_uart_rx_data=byte[3:0].
  - Buffer full: pulse overrun; the new byte is dropped and the buffered byte is kept.
  - If the high nibble is accepted in the same cycle as a commit, the buffer counts as empty: the new byte loads and there is no overrun.
- Handshake:
  - Transfer occurs on vld && acp.
  - data and hi are stable while vld=1 and acp=0.
  - Low nibble accepted -> next cycle hi=1, data=byte[7:4].
  - High nibble accepted -> vld=0 next cycle, unless a simultaneous commit reloads the buffer.
  - acp while vld=0 is ignored.
- Latency: vld rises 1 cycle after the stop-bit sample, about 9.5*CLKS_PER_BIT + SYNC_STAGES + 1 cycles after the start edge.

Optional Feature:
IDLI_UART_RX_PARITY_EN
- With the macro: frame is 8E1. The PARITY state samples at cnt==CLKS_PER_BIT-1. A mismatch against the XOR of the data bits pulses parity_err at the stop sample and discards the byte. A framing error takes precedence; only frame_err pulses.
- Without the macro: 8N1, no PARITY state, parity_err tied 0.

Decomposition:
- Shared package idli_pkg gets:
  - uart_rx_state_t enum.
  - UART_CLKS_PER_BIT default constant, shared with the transmitter.
  - UART_DATA_W=8.
  - Reuse of sqi_data_t.
- Sub-module idli_uart_rx_sync_m: parameterised SYNC_STAGES flop chain with reset value 1.

Test Plan:
1. CLKS_PER_BIT=16, send 0xA5 8N1, acp held 1 -> vld with data=0x5,hi=0, then data=0xA,hi=1 next cycle, then vld=0; no error pulses.
2. Glitch: rx low for 6 cycles, then high -> FSM returns to IDLE from START; vld, frame_err and overrun all stay 0.
3. Send 0x3C with the stop bit forced 0 -> frame_err pulses once; no vld; FSM stays in WAIT_IDLE until the line goes high; a following 0x12 is received as 0x2, 0x1.
4. acp=0, send 0x11 then 0x22 back-to-back -> overrun pulses once; buffer still presents 0x1,0x1. Raise acp exactly on the 0x33 commit cycle after draining the low nibble -> 0x33 loads with no overrun.
5. Assert rst for 1 cycle mid-DATA of 0xFF, then send 0x81 -> all outputs 0 after reset; next outputs are 0x1, 0x8 only.
6. With IDLI_UART_RX_PARITY_EN, send 0x07 with the parity bit = 0 (wrong; expected 1) -> parity_err pulses; no vld. With the correct parity bit 1 -> 0x7, 0x0 delivered.

Source files
------------

// File: rtl/idli_pkg.sv
// Shared idli definitions used by the UART transmitter/receiver and the
// nibble-serial (SQI) datapath.
//   UART_CLKS_PER_BIT : default gck cycles per UART bit (tx and rx)
//   UART_DATA_W       : UART character width
//   sqi_data_t        : one nibble on the core datapath
//   uart_rx_state_t   : receiver FSM states
package idli_pkg;

  localparam int unsigned UART_CLKS_PER_BIT = 16;
  localparam int unsigned UART_DATA_W       = 8;
  localparam int unsigned SQI_DATA_W        = 4;

  typedef logic [SQI_DATA_W-1:0] sqi_data_t;

  typedef enum logic [2:0] {
    UART_RX_IDLE      = 3'd0,
    UART_RX_START     = 3'd1,
    UART_RX_DATA      = 3'd2,
    UART_RX_PARITY    = 3'd3,
    UART_RX_STOP      = 3'd4,
    UART_RX_WAIT_IDLE = 3'd5
  } uart_rx_state_t;

endpackage

// File: rtl/idli_uart_rx_m_if.sv
// UART receiver <-> core bundle: raw serial line in, nibble handshake and
// error pulses out.
//   master : the receiver (drives data/vld/hi/error pulses)
//   slave  : the core/line side (drives the line and acp)
interface idli_uart_rx_m_if;

  logic                  i_uart_rx;
  idli_pkg::sqi_data_t   o_uart_rx_data;
  logic                  o_uart_rx_vld;
  logic                  i_uart_rx_acp;
  logic                  o_uart_rx_hi;
  logic                  o_uart_rx_frame_err;
  logic                  o_uart_rx_overrun;
  logic                  o_uart_rx_parity_err;

  modport master (
    input  i_uart_rx,
    input  i_uart_rx_acp,
    output o_uart_rx_data,
    output o_uart_rx_vld,
    output o_uart_rx_hi,
    output o_uart_rx_frame_err,
    output o_uart_rx_overrun,
    output o_uart_rx_parity_err
  );

  modport slave (
    output i_uart_rx,
    output i_uart_rx_acp,
    input  o_uart_rx_data,
    input  o_uart_rx_vld,
    input  o_uart_rx_hi,
    input  o_uart_rx_frame_err,
    input  o_uart_rx_overrun,
    input  o_uart_rx_parity_err
  );

endinterface

// File: rtl/idli_uart_rx_sync_m.sv
// Flop-chain synchroniser for the asynchronous RX line. Resets to 1 so an
// idle line is seen during and straight after reset.
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_d          : asynchronous input
//   o_q          : synchronised output (last flop of the chain)
module idli_uart_rx_sync_m #(
  parameter int unsigned STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], i_d};
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync_q <= '1;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign o_q = sync_q[STAGES-1];

endmodule

// File: rtl/idli_uart_rx_m.sv
// UART receiver for the idli core. Deframes 8N1 (8E1 with
// IDLI_UART_RX_PARITY_EN defined) characters LSB-first from the RX line,
// holds each byte in a one-byte buffer and hands it to the core as two
// nibbles, low first, over a vld/acp handshake.
//   i_uart_rx_gck  : clock (undivided gck shared with the transmitter)
//   i_uart_rx_rst  : synchronous active-high reset
//   bus.master     : i_uart_rx line, acp in; data/vld/hi, frame_err,
//                    overrun, parity_err pulses out
// Parameters: CLKS_PER_BIT (even, >= 4), SYNC_STAGES (>= 2).
module idli_uart_rx_m
  import idli_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic              i_uart_rx_gck,
  input  logic              i_uart_rx_rst,
  idli_uart_rx_m_if.master  bus
);

  localparam int unsigned      CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam int unsigned      BIT_W    = $clog2(UART_DATA_W);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(UART_DATA_W - 1);

  logic                   rxs;
  uart_rx_state_t         state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [BIT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic [UART_DATA_W-1:0] shreg_q, shreg_d;
  logic                   commit_c;
  logic                   ferr_c;
`ifdef IDLI_UART_RX_PARITY_EN
  logic                   par_bad_q, par_bad_d;
  logic                   perr_c;
  logic                   perr_q;
`endif

  logic [UART_DATA_W-1:0] buf_q, buf_d;
  sqi_data_t              data_q, data_d;
  logic                   vld_q, vld_d;
  logic                   hi_q, hi_d;
  logic                   ferr_q;
  logic                   ovr_q, ovr_d;
  logic                   lo_acc_c;
  logic                   hi_acc_c;
  logic                   buf_free_c;

  // RX line synchroniser
  idli_uart_rx_sync_m #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .i_clk (i_uart_rx_gck),
    .i_rst (i_uart_rx_rst),
    .i_d   (bus.i_uart_rx),
    .o_q   (rxs)
  );

  // Deframing FSM: state register
  always_ff @(posedge i_uart_rx_gck) begin
    if (i_uart_rx_rst) begin
      state_q   <= UART_RX_IDLE;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
`ifdef IDLI_UART_RX_PARITY_EN
      par_bad_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
`ifdef IDLI_UART_RX_PARITY_EN
      par_bad_q <= par_bad_d;
`endif
    end
  end

  // Deframing FSM: next state. cnt wraps to 0 at CNT_LAST, which is also
  // the cycle every sampling transition happens, so each entry reloads 0.
  always_comb begin
    state_d   = state_q;
    cnt_d     = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    commit_c  = 1'b0;
    ferr_c    = 1'b0;
`ifdef IDLI_UART_RX_PARITY_EN
    par_bad_d = par_bad_q;
    perr_c    = 1'b0;
`endif
    case (state_q)
      UART_RX_IDLE: begin
        cnt_d = '0;
        if (!rxs) begin
          state_d = UART_RX_START;
        end
      end
      UART_RX_START: begin
        // Mid start bit: still low means a real start, re-phase to mid-bit
        if (cnt_q == CNT_MID) begin
          cnt_d     = '0;
          bit_cnt_d = '0;
          state_d   = rxs ? UART_RX_IDLE : UART_RX_DATA;
        end
      end
      UART_RX_DATA: begin
        if (cnt_q == CNT_LAST) begin
          shreg_d   = {rxs, shreg_q[UART_DATA_W-1:1]};
          bit_cnt_d = bit_cnt_q + BIT_W'(1);
          if (bit_cnt_q == BIT_LAST) begin
`ifdef IDLI_UART_RX_PARITY_EN
            state_d = UART_RX_PARITY;
`else
            state_d = UART_RX_STOP;
`endif
          end
        end
      end
`ifdef IDLI_UART_RX_PARITY_EN
      UART_RX_PARITY: begin
        // Even parity: line bit must equal XOR of the data bits
        if (cnt_q == CNT_LAST) begin
          par_bad_d = rxs ^ (^shreg_q);
          state_d   = UART_RX_STOP;
        end
      end
`endif
      UART_RX_STOP: begin
        if (cnt_q == CNT_LAST) begin
          if (!rxs) begin
            ferr_c  = 1'b1;
            state_d = UART_RX_WAIT_IDLE;
          end else begin
`ifdef IDLI_UART_RX_PARITY_EN
            perr_c   = par_bad_q;
            commit_c = !par_bad_q;
`else
            commit_c = 1'b1;
`endif
            state_d  = UART_RX_IDLE;
          end
        end
      end
      UART_RX_WAIT_IDLE: begin
        // Hold off until the line returns high so a break reports once
        cnt_d = '0;
        if (rxs) begin
          state_d = UART_RX_IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = UART_RX_IDLE;
      end
    endcase
  end

  // Byte buffer and nibble handshake. Accepting the high nibble frees the
  // buffer in the same cycle, so a coincident commit loads without overrun.
  always_comb begin
    buf_d      = buf_q;
    data_d     = data_q;
    vld_d      = vld_q;
    hi_d       = hi_q;
    ovr_d      = 1'b0;
    lo_acc_c   = vld_q && !hi_q && bus.i_uart_rx_acp;
    hi_acc_c   = vld_q &&  hi_q && bus.i_uart_rx_acp;
    buf_free_c = !vld_q || hi_acc_c;
    if (lo_acc_c) begin
      hi_d   = 1'b1;
      data_d = buf_q[UART_DATA_W-1:SQI_DATA_W];
    end
    if (hi_acc_c) begin
      vld_d  = 1'b0;
      hi_d   = 1'b0;
      data_d = '0;
    end
    if (commit_c) begin
      if (buf_free_c) begin
        buf_d  = shreg_q;
        vld_d  = 1'b1;
        hi_d   = 1'b0;
        data_d = shreg_q[SQI_DATA_W-1:0];
      end else begin
        ovr_d  = 1'b1;
      end
    end
  end

  // Output registers
  always_ff @(posedge i_uart_rx_gck) begin
    if (i_uart_rx_rst) begin
      buf_q  <= '0;
      data_q <= '0;
      vld_q  <= 1'b0;
      hi_q   <= 1'b0;
      ferr_q <= 1'b0;
      ovr_q  <= 1'b0;
`ifdef IDLI_UART_RX_PARITY_EN
      perr_q <= 1'b0;
`endif
    end else begin
      buf_q  <= buf_d;
      data_q <= data_d;
      vld_q  <= vld_d;
      hi_q   <= hi_d;
      ferr_q <= ferr_c;
      ovr_q  <= ovr_d;
`ifdef IDLI_UART_RX_PARITY_EN
      perr_q <= perr_c;
`endif
    end
  end

  assign bus.o_uart_rx_data      = data_q;
  assign bus.o_uart_rx_vld       = vld_q;
  assign bus.o_uart_rx_hi        = hi_q;
  assign bus.o_uart_rx_frame_err = ferr_q;
  assign bus.o_uart_rx_overrun   = ovr_q;
`ifdef IDLI_UART_RX_PARITY_EN
  assign bus.o_uart_rx_parity_err = perr_q;
`else
  assign bus.o_uart_rx_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_idli_uart_rx_m.sv
// Bench for idli_uart_rx_m: table of frames with expected outcomes plus
// hand-written sequences for glitch, break, overrun and mid-frame reset.
// Delivered nibbles are checked against a scoreboard queue.
module tb_idli_uart_rx_m;
  import idli_pkg::*;

  localparam int unsigned N = 16;
`ifdef IDLI_UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int unsigned STOP_IDX    = PAR_EN ? 10 : 9;
  // Cycles from the start-bit drive edge to the stop-sample cycle
  localparam int unsigned STOP_SAMPLE = N / 2 + 2 + STOP_IDX * N;

  typedef struct packed {
    logic      hi;
    logic [3:0] d;
  } nib_t;

  typedef struct {
    logic [7:0] b;
    logic       stop_v;
    logic       par_ok;
    logic       deliver;
    logic       ferr;
    logic       perr;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   ferr_cnt = 0;
  int   ovr_cnt  = 0;
  int   perr_cnt = 0;
  nib_t exp_q[$];

  idli_uart_rx_m_if bus();

  idli_uart_rx_m #(
    .CLKS_PER_BIT (N),
    .SYNC_STAGES  (2)
  ) dut (
    .i_uart_rx_gck (clk),
    .i_uart_rx_rst (rst),
    .bus           (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_byte(input logic [7:0] b);
    exp_q.push_back(nib_t'({1'b0, b[3:0]}));
    exp_q.push_back(nib_t'({1'b1, b[7:4]}));
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives one frame; the line is left at the stop-bit value afterwards
  task automatic send_frame(input logic [7:0] b, input logic stop_v, input logic par_ok);
    logic [10:0] fr;
    int          nb;
    fr      = '0;
    fr[8:1] = b;
    if (PAR_EN) begin
      fr[9]  = (^b) ^ ~par_ok;
      fr[10] = stop_v;
      nb     = 11;
    end else begin
      fr[9]  = stop_v;
      nb     = 10;
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < nb; i++) begin
      bus.i_uart_rx = fr[i];
      tick(N);
    end
  endtask

  // Monitor: pulse counting, hold stability and scoreboard
  logic       prev_ok = 1'b0;
  logic       prev_vld, prev_acp, prev_hi;
  logic [3:0] prev_data;
  always @(negedge clk) begin
    if (rst) begin
      prev_ok = 1'b0;
    end else begin
      ferr_cnt += int'(bus.o_uart_rx_frame_err);
      ovr_cnt  += int'(bus.o_uart_rx_overrun);
      perr_cnt += int'(bus.o_uart_rx_parity_err);
      if (prev_ok && prev_vld && !prev_acp) begin
        check("hold_vld", 32'(bus.o_uart_rx_vld), 32'(1'b1));
        check("hold_nibble", 32'({bus.o_uart_rx_hi, bus.o_uart_rx_data}),
              32'({prev_hi, prev_data}));
      end
      if (bus.o_uart_rx_vld && bus.i_uart_rx_acp) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_nibble: got hi=%0d data=0x%0h, expected none at %0t",
                   bus.o_uart_rx_hi, bus.o_uart_rx_data, $time);
        end else begin
          check("nibble", 32'({bus.o_uart_rx_hi, bus.o_uart_rx_data}), 32'(exp_q.pop_front()));
        end
      end
      prev_vld  = bus.o_uart_rx_vld;
      prev_acp  = bus.i_uart_rx_acp;
      prev_hi   = bus.o_uart_rx_hi;
      prev_data = bus.o_uart_rx_data;
      prev_ok   = 1'b1;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[7];
    int   f0, o0, p0;

    vecs[0] = '{8'hA5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{8'hFF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{8'h3C, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{8'h07, 1'b1, 1'b0, !PAR_EN, 1'b0, PAR_EN};
    vecs[5] = '{8'h07, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{8'h07, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    rst               = 1'b1;
    bus.i_uart_rx     = 1'b1;
    bus.i_uart_rx_acp = 1'b0;
    tick(3);
    rst = 1'b0;

    // Reset state
    check("rst_vld", 32'(bus.o_uart_rx_vld), 32'(0));
    check("rst_data", 32'(bus.o_uart_rx_data), 32'(0));
    check("rst_hi", 32'(bus.o_uart_rx_hi), 32'(0));
    check("rst_ferr", 32'(bus.o_uart_rx_frame_err), 32'(0));
    check("rst_ovr", 32'(bus.o_uart_rx_overrun), 32'(0));
    check("rst_perr", 32'(bus.o_uart_rx_parity_err), 32'(0));
    check("rst_state", 32'(dut.state_q), 32'(UART_RX_IDLE));

    // Table of frames with acp held high
    bus.i_uart_rx_acp = 1'b1;
    for (int i = 0; i < 7; i++) begin
      f0 = ferr_cnt; o0 = ovr_cnt; p0 = perr_cnt;
      if (vecs[i].deliver) expect_byte(vecs[i].b);
      send_frame(vecs[i].b, vecs[i].stop_v, vecs[i].par_ok);
      bus.i_uart_rx = 1'b1;
      tick(N);
      check($sformatf("vec%0d_ferr", i), 32'(ferr_cnt - f0), 32'(vecs[i].ferr));
      check($sformatf("vec%0d_perr", i), 32'(perr_cnt - p0), 32'(vecs[i].perr));
      check($sformatf("vec%0d_ovr", i), 32'(ovr_cnt - o0), 32'(0));
      check($sformatf("vec%0d_drained", i), 32'(exp_q.size()), 32'(0));
      check($sformatf("vec%0d_vld", i), 32'(bus.o_uart_rx_vld), 32'(0));
    end

    // Glitch: 6 low cycles is a false start
    f0 = ferr_cnt; o0 = ovr_cnt;
    bus.i_uart_rx = 1'b0;
    tick(4);
    check("glitch_in_start", 32'(dut.state_q), 32'(UART_RX_START));
    tick(2);
    bus.i_uart_rx = 1'b1;
    tick(20);
    check("glitch_idle", 32'(dut.state_q), 32'(UART_RX_IDLE));
    check("glitch_ferr", 32'(ferr_cnt - f0), 32'(0));
    check("glitch_ovr", 32'(ovr_cnt - o0), 32'(0));
    check("glitch_vld", 32'(bus.o_uart_rx_vld), 32'(0));

    // Break: stop bit low and line held low
    f0 = ferr_cnt;
    send_frame(8'h3C, 1'b0, 1'b1);
    tick(3 * N);
    check("brk_wait_idle", 32'(dut.state_q), 32'(UART_RX_WAIT_IDLE));
    check("brk_ferr_once", 32'(ferr_cnt - f0), 32'(1));
    check("brk_vld", 32'(bus.o_uart_rx_vld), 32'(0));
    bus.i_uart_rx = 1'b1;
    tick(4);
    check("brk_back_idle", 32'(dut.state_q), 32'(UART_RX_IDLE));
    expect_byte(8'h12);
    send_frame(8'h12, 1'b1, 1'b1);
    tick(N);
    check("brk_next_drained", 32'(exp_q.size()), 32'(0));

    // Overrun: two bytes with acp low
    bus.i_uart_rx_acp = 1'b0;
    o0 = ovr_cnt;
    expect_byte(8'h11);
    send_frame(8'h11, 1'b1, 1'b1);
    send_frame(8'h22, 1'b1, 1'b1);
    tick(4);
    check("ovr_once", 32'(ovr_cnt - o0), 32'(1));
    check("ovr_kept_vld", 32'(bus.o_uart_rx_vld), 32'(1));
    check("ovr_kept_nib", 32'({bus.o_uart_rx_hi, bus.o_uart_rx_data}), 32'(5'h01));
    bus.i_uart_rx_acp = 1'b1;
    tick(1);
    bus.i_uart_rx_acp = 1'b0;
    check("ovr_hi_nib", 32'({bus.o_uart_rx_hi, bus.o_uart_rx_data}), 32'(5'h11));
    // High nibble accepted on the commit cycle of 0x33
    o0 = ovr_cnt;
    expect_byte(8'h33);
    fork
      send_frame(8'h33, 1'b1, 1'b1);
      begin
        @(posedge clk);
        tick(STOP_SAMPLE);
        bus.i_uart_rx_acp = 1'b1;
        tick(1);
        bus.i_uart_rx_acp = 1'b0;
      end
    join
    bus.i_uart_rx = 1'b1;
    check("same_cycle_no_ovr", 32'(ovr_cnt - o0), 32'(0));
    check("same_cycle_vld", 32'(bus.o_uart_rx_vld), 32'(1));
    check("same_cycle_nib", 32'({bus.o_uart_rx_hi, bus.o_uart_rx_data}), 32'(5'h03));
    bus.i_uart_rx_acp = 1'b1;
    tick(4);
    check("same_cycle_drained", 32'(exp_q.size()), 32'(0));
    check("same_cycle_vld_low", 32'(bus.o_uart_rx_vld), 32'(0));

    // Reset in the middle of a frame
    f0 = ferr_cnt; o0 = ovr_cnt; p0 = perr_cnt;
    fork
      send_frame(8'hFF, 1'b1, 1'b1);
      begin
        @(posedge clk);
        tick(50);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("midrst_state", 32'(dut.state_q), 32'(UART_RX_IDLE));
        check("midrst_outs", 32'({bus.o_uart_rx_vld, bus.o_uart_rx_hi, bus.o_uart_rx_data,
                                   bus.o_uart_rx_frame_err, bus.o_uart_rx_overrun,
                                   bus.o_uart_rx_parity_err}), 32'(0));
      end
    join
    bus.i_uart_rx = 1'b1;
    tick(N);
    expect_byte(8'h81);
    send_frame(8'h81, 1'b1, 1'b1);
    tick(N);
    check("midrst_drained", 32'(exp_q.size()), 32'(0));
    check("midrst_no_pulses", 32'((ferr_cnt - f0) + (ovr_cnt - o0) + (perr_cnt - p0)), 32'(0));

    tick(4);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
